spi_resp_regs: RTL and testbench

SPI mode-0 responder: the far end of the 16-bit SPI master frame (wrt/cmd/done/rd_data on the master side). Oversamples SCLK/SS_n/MOSI on the system clock and decodes each 16-bit frame as a register read or write into a small internal register file. Shifts a response out on MISO during the following frame. Used as the sensor/peripheral model and as an on-chip command target for the SPI master.

---
 rtl/spi_resp_if.sv | 14 +
 rtl/spi_resp_regs.sv | 100 ++++++++++
 tb/tb_spi_resp_regs.sv | 115 +++++++++++
 3 files changed

// File: rtl/spi_resp_if.sv
// spi_resp_if: SPI pins plus the local register read port of the SPI responder
interface spi_resp_if #(parameter int NUM_REGS = 8);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic rdy;
  logic [15:0] cmd_rcvd;
  logic [AW-1:0] loc_addr;
  logic [7:0] loc_data;
  modport master(output SS_n, SCLK, MOSI, loc_addr, input MISO, rdy, cmd_rcvd, loc_data);
  modport slave(input SS_n, SCLK, MOSI, loc_addr, output MISO, rdy, cmd_rcvd, loc_data);
endinterface

// File: rtl/spi_resp_regs.sv
// spi_resp_regs: oversampled SPI mode-0 responder decoding 16-bit frames into a small register file
module spi_resp_regs #(
  parameter int NUM_REGS = 8,
  parameter logic [7:0] WHOAMI = 8'h6A
) (
  input logic clk,
  input logic rst_n,
  spi_resp_if.slave bus
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [2:0] ss_q, ss_d, sclk_q, sclk_d;
  logic [1:0] mosi_q, mosi_d;
  logic [15:0] tx_q, tx_d, rx_q, rx_d, resp_q, resp_d, cmd_q, cmd_d;
  logic [4:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [6:0] addr;
  logic [AW-1:0] ra;
  logic in_range, wr;
  logic [7:0] rdata;
  assign ss_d = {ss_q[1:0], bus.SS_n};
  assign sclk_d = {sclk_q[1:0], bus.SCLK};
  assign mosi_d = {mosi_q[0], bus.MOSI};
  assign ss_rise = ss_q[1] & ~ss_q[2];
  assign ss_fall = ~ss_q[1] & ss_q[2];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign addr = rx_q[14:8];
  assign ra = addr[AW-1:0];
  assign in_range = int'(addr) < NUM_REGS;
  assign wr = rx_q[15] & (addr != 7'd0) & in_range;
  assign rdata = (addr == 7'd0) ? WHOAMI : !in_range ? 8'h00 : wr ? rx_q[7:0] : regs_q[ra];
  assign bus.MISO = tx_q[15];
  assign bus.rdy = rdy_q;
  assign bus.cmd_rcvd = cmd_q;
  assign bus.loc_data = (bus.loc_addr == '0) ? WHOAMI : (int'(bus.loc_addr) < NUM_REGS) ? regs_q[bus.loc_addr] : 8'h00;
  // all state: synchronizers, FSM, shifters, response and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ss_q <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
      tx_q <= '0;
      rx_q <= '0;
      resp_q <= '0;
      cmd_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ss_q <= ss_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      resp_q <= resp_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      regs_q <= regs_d;
    end
  end
  // frame boundaries follow the synchronized slave select edges
  always_comb begin
    state_d = (state_q == IDLE) ? (ss_fall ? SHIFT : IDLE) : (ss_rise ? IDLE : SHIFT);
  end
  // shifting, frame decode and register write; slave select release wins over SCLK edges
  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    cnt_d = cnt_q;
    resp_d = resp_q;
    cmd_d = cmd_q;
    rdy_d = 1'b0;
    regs_d = regs_q;
    if (state_q == IDLE) begin
      tx_d = resp_q;
      if (ss_fall) cnt_d = '0;
    end else if (ss_rise) begin
      if (cnt_q == 5'd16) begin
        rdy_d = 1'b1;
        cmd_d = rx_q;
        resp_d = {rx_q[15:8], rdata};
        if (wr) regs_d[ra] = rx_q[7:0];
      end
    end else begin
      if (sclk_rise) begin
        rx_d = {rx_q[14:0], mosi_q[1]};
        cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
      end
      if (sclk_fall && cnt_q != 5'd0) tx_d = {tx_q[14:0], 1'b0};
    end
  end
endmodule

// File: tb/tb_spi_resp_regs.sv
// tb_spi_resp_regs: directed SPI frames against spi_resp_regs with hand-computed responses
module tb_spi_resp_regs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;
  int r0;
  logic [15:0] rd;
  spi_resp_if #(.NUM_REGS(8)) bus();
  spi_resp_regs #(.NUM_REGS(8), .WHOAMI(8'h6A)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  // count clocks on which rdy is high
  always @(negedge clk) if (bus.rdy) rdy_cnt++;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic xfer(input logic [15:0] c, input int n, output logic [15:0] r);
    r = '0;
    bus.SS_n = 1'b0;
    clks(5);
    for (int i = 0; i < n; i++) begin
      bus.MOSI = c[15-i];
      clks(5);
      r = {r[14:0], bus.MISO};
      bus.SCLK = 1'b1;
      clks(5);
      bus.SCLK = 1'b0;
    end
    clks(5);
    bus.SS_n = 1'b1;
    clks(10);
  endtask
  task automatic frame(input logic [15:0] c, input logic [15:0] exp_rd, input string tag);
    int s;
    logic [15:0] r;
    s = rdy_cnt;
    xfer(c, 16, r);
    chk({tag, " rd"}, r, exp_rd);
    chk({tag, " rdy"}, 16'(rdy_cnt - s), 16'd1);
    chk({tag, " cmd"}, bus.cmd_rcvd, c);
  endtask
  task automatic loc(input logic [2:0] a, input logic [7:0] e, input string tag);
    bus.loc_addr = a;
    clks(1);
    chk(tag, {8'h00, bus.loc_data}, {8'h00, e});
  endtask
  initial begin
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    bus.loc_addr = '0;
    clks(3);
    chk("rst miso", {15'd0, bus.MISO}, 16'd0);
    chk("rst rdy", {15'd0, bus.rdy}, 16'd0);
    chk("rst cmd", bus.cmd_rcvd, 16'h0000);
    loc(3'd0, 8'h6A, "rst reg0");
    rst_n = 1'b1;
    clks(3);
    loc(3'd3, 8'h00, "rst reg3");
    frame(16'h8355, 16'h0000, "w3");
    loc(3'd3, 8'h55, "reg3 written");
    frame(16'h0300, 16'h8355, "r3");
    frame(16'h0000, 16'h0355, "r3 resp");
    frame(16'h0000, 16'h006A, "r0");
    frame(16'h80FF, 16'h006A, "w0");
    frame(16'h0000, 16'h806A, "w0 resp");
    loc(3'd0, 8'h6A, "reg0 ro");
    frame(16'h8A12, 16'h006A, "w10");
    loc(3'd2, 8'h00, "w10 reg2");
    loc(3'd3, 8'h55, "w10 reg3");
    frame(16'h0000, 16'h8A00, "w10 resp");
    r0 = rdy_cnt;
    xfer(16'h8133, 9, rd);
    chk("abort rdy", 16'(rdy_cnt - r0), 16'd0);
    chk("abort cmd", bus.cmd_rcvd, 16'h0000);
    loc(3'd1, 8'h00, "abort reg1");
    frame(16'h8142, 16'h006A, "w1");
    loc(3'd1, 8'h42, "reg1 written");
    frame(16'h0000, 16'h8142, "w1 resp");
    r0 = rdy_cnt;
    bus.SS_n = 1'b0;
    clks(5);
    for (int i = 0; i < 8; i++) begin
      bus.MOSI = ((16'h87FF >> (15 - i)) & 16'h1) != 16'h0;
      clks(5);
      bus.SCLK = 1'b1;
      clks(5);
      bus.SCLK = 1'b0;
    end
    rst_n = 1'b0;
    bus.SS_n = 1'b1;
    clks(1);
    chk("midrst miso", {15'd0, bus.MISO}, 16'd0);
    clks(2);
    rst_n = 1'b1;
    clks(10);
    chk("midrst rdy", 16'(rdy_cnt - r0), 16'd0);
    chk("midrst cmd", bus.cmd_rcvd, 16'h0000);
    chk("midrst miso idle", {15'd0, bus.MISO}, 16'd0);
    loc(3'd7, 8'h00, "midrst reg7");
    loc(3'd1, 8'h00, "midrst reg1");
    frame(16'h0700, 16'h0000, "r7");
    frame(16'h0000, 16'h0700, "r7 resp");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
